// File: rtl/icache_refill.sv
// Instruction-cache miss handler: fetches one aligned block byte-by-byte from
// the arbitrated RAM port and hands it to the cache as a single-cycle fill.
//
// state | meaning
// IDLE  | waiting for a miss; block base latched on entry to REQ
// REQ   | RAM port requested, waiting for grant
// READ  | issuing byte addresses and capturing returned bytes (one behind)
// DONE  | one-cycle fill strobe to the cache
module icache_refill #(
  parameter int BLK_INSTR = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   miss_in,
  input  logic [ADDR_W-1:0]      if_ain,
  input  logic                   flush_in,
  output logic                   mem_req_out,
  input  logic                   mem_gnt_in,
  output logic [ADDR_W-1:0]      mem_a_out,
  input  logic [7:0]             mem_din,
  output logic                   fill_en_out,
  output logic [ADDR_W-1:0]      fill_addr_out,
  output logic [BLK_INSTR*32-1:0] fill_data_out,
  output logic                   busy_out
);

  localparam int BLK_BYTES = BLK_INSTR * 4;
  localparam int OFF_W     = $clog2(BLK_BYTES);
  localparam int CNT_W     = OFF_W + 1;
  localparam int DATA_W    = BLK_BYTES * 8;

  typedef enum logic [1:0] {IDLE, REQ, READ, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    issue_q;
  logic [CNT_W-1:0]    rcv_q;
  logic                rd_vld_q;
  logic [DATA_W-1:0]   buf_q;
  logic [DATA_W-1:0]   buf_d;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_a_q;
  logic                fill_en_q;
  logic [ADDR_W-1:0]   fill_addr_q;
  logic [DATA_W-1:0]   fill_data_q;
  logic                busy_q;

  // Assembly buffer with the incoming byte dropped into its little-endian slot.
  always_comb begin
    buf_d = buf_q;
    buf_d[{rcv_q[OFF_W-1:0], 3'b000} +: 8] = mem_din;
  end

  // Refill sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_q     <= '0;
      rcv_q       <= '0;
      rd_vld_q    <= 1'b0;
      buf_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_a_q     <= '0;
      fill_en_q   <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      fill_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_in && !flush_in) begin
            base_q    <= if_ain & ~ADDR_W'(BLK_BYTES - 1);
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (flush_in) begin
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (mem_gnt_in) begin
            // First address goes out in the first READ cycle, so the issue
            // counter already points at the second byte.
            mem_a_q  <= base_q;
            issue_q  <= CNT_W'(1);
            rcv_q    <= '0;
            rd_vld_q <= 1'b0;
            state_q  <= READ;
          end
        end
        READ: begin
          if (flush_in) begin
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            if (issue_q < CNT_W'(BLK_BYTES)) begin
              mem_a_q <= base_q + ADDR_W'(issue_q);
              issue_q <= issue_q + 1'b1;
            end
            // RAM data trails the address by one cycle.
            rd_vld_q <= 1'b1;
            if (rd_vld_q) begin
              buf_q <= buf_d;
              rcv_q <= rcv_q + 1'b1;
              if (rcv_q == CNT_W'(BLK_BYTES - 1)) begin
                mem_req_q   <= 1'b0;
                fill_en_q   <= 1'b1;
                fill_addr_q <= base_q;
                fill_data_q <= buf_d;
                state_q     <= DONE;
              end
            end
          end
        end
        DONE: begin
          // A flush here is ignored: the fetched block is valid regardless.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_out   = mem_req_q;
  assign mem_a_out     = mem_a_q;
  assign fill_en_out   = fill_en_q;
  assign fill_addr_out = fill_addr_q;
  assign fill_data_out = fill_data_q;
  assign busy_out      = busy_q;

endmodule
